// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, ALU control constants, flag struct and opcode decode shared by the issue stage
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND, OP_ILLEGAL
  } alu_op_e;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_NAND = 4'b1101;

  typedef struct packed {
    logic zero;
    logic cout;
    logic overflow;
  } alu_flags_t;

  // Illegal opcodes fall through to the AND encoding (all zero).
  function automatic logic [3:0] op_to_ctrl(input logic [2:0] op);
    case (op)
      OP_OR:   return CTRL_OR;
      OP_ADD:  return CTRL_ADD;
      OP_SUB:  return CTRL_SUB;
      OP_SLT:  return CTRL_SLT;
      OP_NOR:  return CTRL_NOR;
      OP_NAND: return CTRL_NAND;
      default: return CTRL_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: 2-entry FIFO of captured ALU results; caller never pushes when full unless popping
module alu_result_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wp, rp;

  assign dout = mem[rp];

  // Storage and pointers; entries are cleared on reset so the head reads as zero when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand issue and result capture around an external ALU; ALU_ISSUE_SKID_EN selects the pipelined skid build
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_overflow,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);
  logic             live, accept, ex_err;
  logic [TAG_W-1:0] ex_tag;
  logic [31:0]      cap_result;
  alu_flags_t       cap_flags;

  assign accept     = in_valid && in_ready;
  assign cap_result = ex_err ? 32'd0 : alu_result;
  assign cap_flags  = alu_flags_t'(ex_err ? 3'b000 : {alu_zero, alu_cout, alu_overflow});

  // Holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Operand register driving the ALU during the execute cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_src1 <= '0;
      alu_src2 <= '0;
      alu_ctrl <= CTRL_AND;
      ex_err   <= 1'b0;
      ex_tag   <= '0;
    end else if (accept) begin
      alu_src1 <= in_src1;
      alu_src2 <= in_src2;
      alu_ctrl <= op_to_ctrl(in_op);
      ex_err   <= in_op == OP_ILLEGAL;
      ex_tag   <= in_tag;
    end
  end

`ifdef ALU_ISSUE_SKID_EN
  localparam int W = 32 + 3 + 1 + TAG_W;
  logic         ex_valid, pop;
  logic [1:0]   count;
  logic [2:0]   occ;
  logic [W-1:0] dout;

  assign pop       = out_valid && out_ready;
  assign occ       = {1'b0, count} + {2'b0, ex_valid};
  // A slot freed by this cycle's drain may be refilled at the same edge
  assign in_ready  = live && (occ < 3'd2 + {2'b0, pop});
  assign out_valid = count != 2'd0;
  assign {out_result, out_zero, out_cout, out_overflow, out_err, out_tag} = dout;

  // Execute-stage occupancy: an accepted op spends exactly one cycle on the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_valid <= 1'b0;
    else        ex_valid <= accept;
  end

  alu_result_fifo #(.W(W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ex_valid),
    .din   ({cap_result, cap_flags, ex_err, ex_tag}),
    .pop   (pop),
    .dout  (dout),
    .count (count)
  );
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
  state_e state, nxt;

  assign in_ready  = live && state == S_IDLE;
  assign out_valid = state == S_DONE;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next state: accept in IDLE, one execute cycle, hold result until drained
  always_comb begin
    nxt = state;
    nxt = state == S_IDLE ? (accept ? S_EXEC : S_IDLE) :
          state == S_EXEC ? S_DONE :
          (out_ready ? S_IDLE : S_DONE);
  end

  // Output register captured at the end of the execute cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result                         <= '0;
      {out_zero, out_cout, out_overflow} <= 3'b000;
      out_err                            <= 1'b0;
      out_tag                            <= '0;
    end else if (state == S_EXEC) begin
      out_result                         <= cap_result;
      {out_zero, out_cout, out_overflow} <= cap_flags;
      out_err                            <= ex_err;
      out_tag                            <= ex_tag;
    end
  end
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed scoreboard bench for alu_issue_stage with a behavioural ALU at the parent level
module tb_alu_issue_stage;
  localparam int TAG_W = 4;
`ifdef ALU_ISSUE_SKID_EN
  localparam int GAP = 1;
  localparam int BP_ACC = 2;
`else
  localparam int GAP = 3;
  localparam int BP_ACC = 1;
`endif

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [2:0] in_op = 0;
  logic [31:0] in_src1 = 0, in_src2 = 0;
  logic [TAG_W-1:0] in_tag = 0, out_tag;
  logic [31:0] alu_src1, alu_src2, alu_result, out_result;
  logic [3:0] alu_ctrl;
  logic alu_zero, alu_cout, alu_overflow, out_zero, out_cout, out_overflow, out_err;

  always #5 clk = ~clk;

  alu_issue_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_cout(alu_cout), .alu_overflow(alu_overflow), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero), .out_cout(out_cout),
    .out_overflow(out_overflow), .out_err(out_err), .out_tag(out_tag)
  );

  // Behavioural ALU driven by the control word
  logic [31:0] ma, mb;
  logic [32:0] ms;
  logic movf, marith;
  assign ma = alu_ctrl[3] ? ~alu_src1 : alu_src1;
  assign mb = alu_ctrl[2] ? ~alu_src2 : alu_src2;
  assign ms = {1'b0, ma} + {1'b0, mb} + {32'b0, alu_ctrl[2]};
  assign movf = (ma[31] == mb[31]) && (ms[31] != ma[31]);
  assign marith = alu_ctrl[1:0] == 2'b10;
  assign alu_result = alu_ctrl[1:0] == 2'b00 ? (ma & mb) :
                      alu_ctrl[1:0] == 2'b01 ? (ma | mb) :
                      alu_ctrl[1:0] == 2'b10 ? ms[31:0] : {31'b0, ms[31] ^ movf};
  assign alu_cout = marith & ms[32];
  assign alu_overflow = marith & movf;
  assign alu_zero = alu_result == 32'd0;

  typedef struct packed {
    logic [31:0] r;
    logic z, c, o, e;
    logic [TAG_W-1:0] t;
  } exp_t;

  localparam logic [3:0] CTAB [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                      4'b0111, 4'b1100, 4'b1101, 4'b0000};

  exp_t q[$];
  int pass_cnt = 0, total = 0, fail_cnt = 0, cyc = 0, acc_n = 0;
  int drain_cyc[$];
  bit acc, drn;

  function automatic exp_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] t);
    exp_t e;
    logic [32:0] s;
    e = '0;
    e.t = t;
    case (op)
      3'd0: e.r = a & b;
      3'd1: e.r = a | b;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        e.r = s[31:0];
        e.c = s[32];
        e.o = (a[31] == b[31]) && (e.r[31] != a[31]);
      end
      3'd3: begin
        e.r = a - b;
        e.c = a >= b;
        e.o = (a[31] != b[31]) && (e.r[31] != a[31]);
      end
      3'd4: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: e.r = ~(a | b);
      3'd6: e.r = ~(a & b);
      default: e.e = 1'b1;
    endcase
    e.z = !e.e && e.r == 32'd0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      chk("result_expected", 64'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("result", {out_result, out_zero, out_cout, out_overflow, out_err, out_tag}, e);
        drain_cyc.push_back(cyc);
      end
    end
    if (acc) begin
      q.push_back(model(in_op, in_src1, in_src2, in_tag));
      acc_n++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic offer(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    in_op = op;
    in_src1 = a;
    in_src2 = b;
    in_tag = t;
    in_valid = 1;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) tick();
    chk("accept_timeout", 64'(acc), 1);
    in_valid = 0;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {out_result, out_zero, out_cout, out_overflow, out_err, out_tag}, 0);
    chk("rst_alu_ports", {alu_src1, alu_src2, alu_ctrl}, 0);
    rst_n = 1;
    #1 chk("rst_release_in_ready", in_ready, 0);
    @(negedge clk);
    chk("first_edge_in_ready", in_ready, 1);

    out_ready = 1;
    offer(3'd2, 32'h7FFF_FFFF, 32'h1, 4'd3);
    chk("add_exec_ctrl", alu_ctrl, 4'b0010);
    chk("add_exec_srcs", {alu_src1, alu_src2}, {32'h7FFF_FFFF, 32'h1});
    chk("add_lat_n1", out_valid, 0);
    tick();
    chk("add_lat_n2", out_valid, 1);
    chk("add_value", {out_result, out_zero, out_cout, out_overflow, out_err, out_tag},
        {32'h8000_0000, 4'b0010, 4'd3});
    drain_all();

    offer(3'd3, 32'd5, 32'd5, 4'd1);
    drain_all();
    offer(3'd4, 32'hFFFF_FFFF, 32'h1, 4'd2);
    drain_all();
    offer(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5);
    chk("illegal_ctrl", alu_ctrl, 4'b0000);
    drain_all();

    for (int op = 0; op < 8; op++) begin
      offer(3'(op), $urandom, $urandom, 4'(op + 8));
      chk("ctrl_map", alu_ctrl, CTAB[op]);
      drain_all();
    end

    out_ready = 0;
    acc_n = 0;
    offer(3'd0, 32'hF0F0_1234, 32'hFFFF_0000, 4'd9);
    tick();
    in_op = 3'd1;
    in_src1 = 32'h0000_00A5;
    in_src2 = 32'h0000_5A00;
    in_tag = 4'd10;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
`ifndef ALU_ISSUE_SKID_EN
      chk("bp_in_ready", in_ready, 0);
`endif
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold", {out_result, out_zero, out_cout, out_overflow, out_err, out_tag}, q[0]);
      tick();
    end
    chk("bp_accepts", acc_n, BP_ACC);
    in_valid = 0;
    out_ready = 1;
    drain_all();

    drain_cyc.delete();
    for (int t = 0; t < 8; t++) offer(3'd2, $urandom, $urandom, 4'(t));
    drain_all();
    chk("b2b_count", drain_cyc.size(), 8);
    for (int i = 1; i < drain_cyc.size(); i++) chk("b2b_gap", drain_cyc[i] - drain_cyc[i-1], GAP);

    offer(3'd2, 32'd1, 32'd2, 4'd6);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    q.delete();
    tick();
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      chk("no_stale", out_valid, 0);
      tick();
    end
    offer(3'd3, 32'd9, 32'd4, 4'd7);
    drain_all();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-issue and result-capture stage wrapped around the combinational 32-bit ALU. It accepts operations from decode through a valid/ready handshake and translates a compact opcode into the ALU's 4-bit control word. It holds the operands stable on the ALU inputs for one execute cycle, then registers the result and flags toward writeback through a second valid/ready handshake. Throughput is one operation per three cycles in the base build, or one per cycle with the skid buffer compiled in.

## Interface
- TAG_W, 4, width of the transaction tag carried from input to output
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  operation offered
- in_ready  output  1  stage accepts operation this cycle
- in_op  input  3  opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6 NAND, 7 illegal
- in_src1, in_src2  input  32  operands
- in_tag  input  TAG_W  transaction tag
- alu_src1, alu_src2  output  32  registered operands to the ALU
- alu_ctrl  output  4  ALU control: {A_invert, B_invert/cin, operation[1:0]}
- alu_result  input  32  ALU result
- alu_zero, alu_cout, alu_overflow  input  1  ALU flags
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_result  output  32  captured result
- out_zero, out_cout, out_overflow  output  1  captured flags
- out_err  output  1  operation carried an illegal opcode
- out_tag  output  TAG_W  tag of the result

## Operation
- Opcode to alu_ctrl mapping:
  - AND 0000
  - OR 0001
  - ADD 0010
  - SUB 0110
  - SLT 0111
  - NOR 1100
  - NAND 1101
  - illegal drives 0000.
- Handshake: a transfer occurs when valid && ready on the rising edge. in_ready depends only on internal state, never combinationally on in_valid. out_* remain stable while out_valid && !out_ready.
- FSM, base build:
  - IDLE: in_ready=1. On accept, register operands, alu_ctrl and tag, then go to EXEC.
  - EXEC: in_ready=0. The ALU evaluates the registered operands. At the edge, capture alu_result and the flags into the output register, then go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Illegal opcode: the operation still traverses EXEC. The stage captures out_result=0, out_zero=0, out_cout=0, out_overflow=0 and out_err=1. For legal opcodes out_err=0.
- Flags are passed through from the ALU unmodified; the ALU itself masks cout and overflow to ADD/SUB.
- alu_src*/alu_ctrl hold their last value outside EXEC; there is no requirement to zero them.
- Tags are returned strictly in acceptance order.

## Timing
- Reset values:
  - in_ready=0 during reset, then 1 from the first edge after rst_n rises.
  - out_valid=0, out_result=0, all flags 0, out_err=0, out_tag=0.
  - alu_src1=0, alu_src2=0, alu_ctrl=0000.
  - FSM in IDLE.
- Latency: accept at edge N, so the ALU is driven during cycle N+1 and out_valid=1 in cycle N+2. That is 2 cycles, independent of opcode.
- Base throughput: one operation per 3 cycles with out_ready held high, because DONE→IDLE costs a cycle.
- Reset mid-operation: an in-flight or held result is discarded and not presented after reset.
- in_valid with in_ready=0: the offer is ignored. Upstream must hold the offer; the stage does not latch it.

## Configuration
- ALU_ISSUE_SKID_EN defined:
  - The FSM is replaced by a pipelined EXEC register plus a 2-entry output FIFO.
  - in_ready = (fifo_count + exec_valid) < 2.
  - Accept and drain may occur in the same cycle.
  - With out_ready held high, throughput is 1 op/cycle and latency remains 2 cycles.
  - When full with out_ready=0, the stage holds both entries; nothing is dropped or overwritten.
  - Simultaneous push and pop on a full FIFO is legal and keeps the count.
- ALU_ISSUE_SKID_EN undefined: behaviour is the 3-state FSM above, exactly.

## Structure
- Shared package alu_pkg:
  - opcode enum (OP_AND…OP_ILLEGAL).
  - the 4-bit ALU control constants.
  - an alu_flags_t struct {zero, cout, overflow}.
  - a function op_to_ctrl().
- One sub-module, alu_result_fifo: a 2-entry FIFO of {result, flags, err, tag}, instantiated only under ALU_ISSUE_SKID_EN.
- The ALU is instantiated outside this block, at the parent level.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001, tag 3 → result 0x80000000, overflow=1, cout=0, zero=0, tag 3, out_valid at cycle N+2.
- SUB 5 − 5 → result 0, zero=1, cout=1, overflow=0. SLT 0xFFFFFFFF vs 0x00000001 → result 1.
- in_op=7 with src1=src2=0xFFFFFFFF → out_err=1, result 0, all flags 0, alu_ctrl=0000.
- Hold out_ready=0 for 10 cycles after a result:
  - base build: in_ready=0 throughout.
  - skid build: exactly 2 ops accepted, then results drain in order once out_ready=1.
- Back-to-back ops with tags 0..7, out_ready=1 (skid build) → 8 results on consecutive cycles, tags in order.
- Assert rst_n=0 during EXEC → out_valid=0 immediately, no stale result after release, next op completes normally.
